// File: rtl/pwm_duty_modulator.sv
// pwm_duty_modulator: prescaled edge/centre-aligned PWM with duty and mode latched at frame boundaries.
module pwm_duty_modulator #(
    parameter int WIDTH    = 6,
    parameter int PRESCALE = 1
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             Enable,
    input  logic             Centre_Mode,
    input  logic [WIDTH-1:0] Duty_In,
    output logic             PWM_Out,
    output logic             Frame_Start,
    output logic [WIDTH-1:0] Duty_Latched,
    output logic [WIDTH-1:0] Count
);
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    localparam logic [WIDTH-1:0] MAX = '1;

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t           state, state_n;
    logic [PW-1:0]    presc, presc_n;
    logic [WIDTH-1:0] count_n, duty_n;
    logic             mode, mode_n, tick, start, stop;

    assign tick = presc == PW'(PRESCALE - 1);

    always_comb begin
        start   = state == IDLE ? Enable
                : Enable && tick && (state == UP ? (Count == MAX && !mode) : Count <= 1);
        stop    = state != IDLE && !Enable;
        state_n = stop ? IDLE
                : start ? UP
                : (state == UP && tick && Count == MAX) ? DOWN : state;
        count_n = (stop || start) ? '0
                : (!tick || state == IDLE) ? Count
                : state == UP ? (Count == MAX ? MAX - 1'b1 : Count + 1'b1)
                : Count - 1'b1;
        presc_n = (stop || start || state == IDLE || tick) ? '0 : presc + 1'b1;
        duty_n  = start ? Duty_In : stop ? '0 : Duty_Latched;
        mode_n  = start ? Centre_Mode : stop ? 1'b0 : mode;
    end

    // PWM_Out is computed from the next-state values so it tracks Count with no lag.
    always_ff @(posedge sysclk) begin
        if (reset) begin
            state        <= IDLE;
            Count        <= '0;
            presc        <= '0;
            Duty_Latched <= '0;
            mode         <= 1'b0;
            PWM_Out      <= 1'b0;
            Frame_Start  <= 1'b0;
        end else begin
            state        <= state_n;
            Count        <= count_n;
            presc        <= presc_n;
            Duty_Latched <= duty_n;
            mode         <= mode_n;
            PWM_Out      <= state_n != IDLE && count_n < duty_n;
            Frame_Start  <= start;
        end
    end
endmodule
